// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg
// Definitions shared by the count monitor and any counter built next to it:
//   state_t   - monitor FSM state; the encoding is visible on the debug output.
//   successor - the next value of a wrapping 0..max_count counter, given its
//               current value and enable. A disabled counter holds its value.
package count_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  function automatic logic [31:0] successor(input logic [31:0] prev,
                                            input logic        en,
                                            input logic [31:0] max_count);
    if (!en) return prev;
    return (prev == max_count) ? 32'd0 : prev + 32'd1;
  endfunction

endpackage

// File: rtl/count_successor.sv
// count_successor
// Purely combinational successor/legality logic for a 0..MAX_COUNT counter.
// It is shared by the counter and by the monitor that checks the counter.
// Ports:
//   prev     in  WIDTH  current counter value
//   en       in  1      counter enable for this cycle
//   expected out WIDTH  value the counter takes after this cycle
//   legal    out 1      prev lies within 0..MAX_COUNT
module count_successor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 9
) (
  input  logic [WIDTH-1:0] prev,
  input  logic             en,
  output logic [WIDTH-1:0] expected,
  output logic             legal
);

  assign expected = WIDTH'(successor(32'(prev), en, 32'(MAX_COUNT)));
  assign legal    = (32'(prev) <= 32'(MAX_COUNT));

endmodule

// File: rtl/parameterized_count_monitor.sv
// parameterized_count_monitor
// Watches the output of an upstream wrapping counter (0..MAX_COUNT) together
// with the enable driven to it. It flags out-of-order values, out-of-range
// values and a counter that stays out of range for too long. It also keeps
// a saturating error count with a sticky alarm.
// Ports:
//   clk           in   1      clock, rising edge
//   rst           in   1      synchronous active-high reset
//   count_in      in   WIDTH  observed count value
//   enable_in     in   1      enable sent to the counter in the same cycle
//   clr           in   1      clears error_count and alarm
//   seq_error     out  1      pulse: legal value that is not the expected successor
//   illegal_value out  1      pulse: count_in > MAX_COUNT
//   stuck         out  1      pulse: no legal value for RECOVER_TIMEOUT cycles
//   wrap          out  1      pulse: legal MAX_COUNT -> 0 step while tracking
//   error_count   out  ERR_W  saturating count of error events
//   alarm         out  1      sticky, set when error_count reaches ALARM_THRESH
//   state         out  2      FSM state (IDLE=0, TRACK=1, RECOVER=2)
// Every pulse is registered. A sample seen in cycle n produces its pulse in
// cycle n+1.
module parameterized_count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int MAX_COUNT       = 9,
  parameter int ERR_W           = 8,
  parameter int ALARM_THRESH    = 4,
  parameter int RECOVER_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             enable_in,
  input  logic             clr,
  output logic             seq_error,
  output logic             illegal_value,
  output logic             stuck,
  output logic             wrap,
  output logic [ERR_W-1:0] error_count,
  output logic             alarm,
  output logic [1:0]       state
);

  localparam int               TW      = $clog2(RECOVER_TIMEOUT + 1);
  localparam logic [TW-1:0]    TMR_TOP = TW'(RECOVER_TIMEOUT - 1);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_COUNT);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_count;
  logic             prev_en;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             sample_legal;
  logic [TW-1:0]    timer_q, timer_d;
  logic             seq_d, ill_d, stuck_d, wrap_d;
  logic             err_event;

  // The successor of the current sample is computed now and registered.
  // Next cycle expected_q therefore equals the successor of
  // (prev_count, prev_en). The same instance also reports whether the
  // current sample is legal.
  count_successor #(
    .WIDTH    (WIDTH),
    .MAX_COUNT(MAX_COUNT)
  ) u_succ (
    .prev    (count_in),
    .en      (enable_in),
    .expected(expected_d),
    .legal   (sample_legal)
  );

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    seq_d   = 1'b0;
    ill_d   = 1'b0;
    stuck_d = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_legal) begin
          state_d = ST_TRACK;
        end else begin
          state_d = ST_RECOVER;
          ill_d   = 1'b1;
        end
      end
      ST_TRACK: begin
        if (!sample_legal) begin
          state_d = ST_RECOVER;
          ill_d   = 1'b1;
        end else if (count_in != expected_q) begin
          // prev_count is reloaded from the sample anyway, so the monitor
          // resyncs to the new value without extra logic.
          seq_d = 1'b1;
        end else if (prev_en && prev_count == MAX_V) begin
          wrap_d = 1'b1;
        end
      end
      ST_RECOVER: begin
        if (sample_legal) begin
          state_d = ST_TRACK;
        end else if (timer_q == TMR_TOP) begin
          stuck_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The FSM raises at most one of these per cycle.
  assign err_event = ill_d | stuck_d | seq_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      prev_count    <= '0;
      prev_en       <= 1'b0;
      expected_q    <= '0;
      timer_q       <= '0;
      seq_error     <= 1'b0;
      illegal_value <= 1'b0;
      stuck         <= 1'b0;
      wrap          <= 1'b0;
      error_count   <= '0;
      alarm         <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_count    <= count_in;
      prev_en       <= enable_in;
      expected_q    <= expected_d;
      timer_q       <= timer_d;
      seq_error     <= seq_d;
      illegal_value <= ill_d;
      stuck         <= stuck_d;
      wrap          <= wrap_d;
      if (clr) begin
        // An error event in the same cycle as clr is dropped.
        error_count <= '0;
        alarm       <= 1'b0;
      end else if (err_event && error_count != ERR_MAX) begin
        error_count <= error_count + ERR_W'(1);
        if (32'(error_count) + 32'd1 >= 32'(ALARM_THRESH)) alarm <= 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: doc/parameterized_count_monitor.md
PARAMETERIZED_COUNT_MONITOR -- requirements
Module: parameterized_count_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of the observed count bus.
REQ-002 SHALL have parameter MAX_COUNT, default 9: highest legal count value; the counter wraps MAX_COUNT -> 0.
REQ-003 SHALL have parameter ERR_W, default 8: width of the error counter.
REQ-004 SHALL have parameter ALARM_THRESH, default 4: error count at which alarm asserts.
REQ-005 SHALL have parameter RECOVER_TIMEOUT, default 16: maximum cycles in RECOVER before a stuck event.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 count_in  input  WIDTH  count value from the upstream self-correcting counter.
REQ-009 enable_in  input  1  the enable driven to the upstream counter in the same cycle.
REQ-010 clr  input  1  synchronous clear of error_count and alarm.
REQ-011 seq_error  output  1  one-cycle pulse: legal value but not the expected successor.
REQ-012 illegal_value  output  1  one-cycle pulse: count_in > MAX_COUNT.
REQ-013 stuck  output  1  one-cycle pulse: RECOVER timeout expired.
REQ-014 wrap  output  1  one-cycle pulse: observed legal MAX_COUNT -> 0 step while tracking.
REQ-015 error_count  output  ERR_W  saturating count of error events.
REQ-016 alarm  output  1  sticky flag: error_count >= ALARM_THRESH.
REQ-017 state  output  2  FSM state: IDLE=0, TRACK=1, RECOVER=2.

Function
REQ-018 SHALL register count_in and enable_in each cycle as prev_count and prev_en.
REQ-019 SHALL compute expected = prev_en ? (prev_count == MAX_COUNT ? 0 : prev_count + 1) : prev_count.
REQ-020 SHALL register all pulse outputs: a sample presented in cycle n SHALL produce its pulse in cycle n+1, high for exactly one cycle.
REQ-021 IDLE: SHALL capture the first sample without a sequence check; legal -> TRACK, illegal -> RECOVER with an illegal_value event.
REQ-022 TRACK, illegal sample: SHALL pulse illegal_value, count one error, go to RECOVER.
REQ-023 TRACK, legal sample != expected: SHALL pulse seq_error, count one error, stay in TRACK, and resync prev_count to the sample.
REQ-024 TRACK, sample == expected with prev_count == MAX_COUNT and prev_en = 1: SHALL pulse wrap; no error.
REQ-025 RECOVER: SHALL skip the sequence check and increment a timeout counter each cycle; the first legal sample SHALL resync, clear the timer and return to TRACK with no error.
REQ-026 RECOVER: when the timer reaches RECOVER_TIMEOUT without a legal sample, SHALL pulse stuck, count one error, restart the timer and stay in RECOVER.
REQ-027 SHALL count at most one error event per cycle; priority is illegal_value > stuck > seq_error, and lower-priority pulses SHALL be suppressed.
REQ-028 error_count SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-029 alarm SHALL assert in the same cycle error_count first equals ALARM_THRESH, and SHALL stay high until clr or rst.
REQ-030 clr SHALL zero error_count and alarm next cycle; an error event in the same cycle SHALL be dropped (clr wins); pulses and FSM are unaffected.
REQ-031 enable_in = 0 SHALL make the expected value a hold; a change while disabled is a seq_error.

Reset
REQ-032 rst SHALL take priority over all inputs including clr.
REQ-033 rst SHALL force state=IDLE; all pulses, error_count, alarm, prev_count, prev_en and the timeout counter to 0.
REQ-034 rst asserted mid-RECOVER or mid-alarm SHALL discard all history; the first post-reset sample is treated per REQ-021.

Structure
REQ-035 The FSM state enum and encodings SHALL live in shared package count_monitor_pkg, with a successor-function helper.
REQ-036 Successor/legality logic SHALL be one sub-module, count_successor (inputs prev, en; outputs expected, legal), reusable by the counter and the monitor.
REQ-037 No other sub-modules; the implementation SHALL be 120-400 lines of RTL.

Verification
REQ-038 enable_in=1, counts 0..9,0,1 -> no errors, wrap pulse once in the cycle after the 0 sample, state=TRACK.
REQ-039 In TRACK, inject 3 after 5 with enable=1 -> seq_error pulse, error_count=1; next 4 is accepted silently.
REQ-040 Inject 12, then 0 -> illegal_value pulse, state=RECOVER, then TRACK; error_count +1.
REQ-041 Hold count_in=15 for 20 cycles -> illegal_value once, then stuck pulse 16 cycles after entering RECOVER, error_count=2.
REQ-042 Four errors -> alarm=1 at error_count=4; clr coinciding with a fifth error -> error_count=0, alarm=0.
REQ-043 rst mid-RECOVER with error_count=3 -> state=IDLE, all outputs 0 the next cycle.
